mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 20 ++
 rtl/mem_responder_if.sv | 31 +++
 rtl/mem_responder_array.sv | 49 ++++
 rtl/mem_responder.sv | 163 ++++++++++++++++
 tb/tb_mem_responder.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
// Shared definitions for the memory responder: FSM state encoding, the word
// returned for a faulting read, and the wait-state limit that sizes the
// wait counter.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Returned on rdata for a read that faults the bus-error check.
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  // Largest supported WAIT_CYCLES value; sets the wait counter width.
  localparam int MAX_WAIT_CYCLES = 15;
  localparam int CNT_W           = $clog2(MAX_WAIT_CYCLES + 1);

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if
// CPU-controller <-> memory-responder bus.
//   mem_read / mem_write : request strobes (controller -> responder)
//   addr                 : byte address, addr[1:0] ignored for indexing
//   wdata                : write data
//   rdata                : registered read data (responder -> controller)
//   ready                : one-cycle completion pulse
//   busy                 : request in flight, stalls the controller
//   err                  : access-error flag, valid with ready
interface mem_responder_if;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, ready, busy, err
  );

endinterface

// File: rtl/mem_responder_array.sv
// mem_responder_array
// Single-port word storage for the memory responder: synchronous write,
// registered read. Every word returns to INIT_WORD and the read register to
// zero while rst is low.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   i_we     : write enable, commits i_wdata to word i_idx
//   i_re     : read enable, loads word i_idx into the read register
//   i_idx    : word index
//   i_wdata  : write data
//   o_rdata  : read register, holds its value until the next i_re
module mem_responder_array #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] INIT_WORD  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= INIT_WORD;
      end
      r_rdata <= '0;
    end else begin
      if (i_we) begin
        r_mem[i_idx] <= i_wdata;
      end
      if (i_re) begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Memory responder for a CPU controller: accepts one read or write request
// in IDLE, inserts WAIT_CYCLES wait states, then pulses ready for one cycle
// in DONE. Reads and writes take effect on the edge entering DONE.
// Optional feature: define MEM_RESPONDER_BUSERR_EN to flag misaligned or
// out-of-range addresses (err=1 with ready, write suppressed, read returns
// ERR_WORD). Without it, address bits outside the index alias and err is 0.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : mem_responder_if slave (strobes, addr, wdata in; rdata, ready,
//          busy, err out)
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] INIT_WORD   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic              r_is_wr;
  logic              r_is_rd;
  logic              r_ready;
  logic              r_err;

  logic              w_req;
  logic              w_in_idle;
  logic              w_op_wr;
  logic              w_op_rd;
  logic [31:0]       w_op_addr;
  logic [31:0]       w_op_wdata;
  logic              w_enter_done;
  logic              w_err;
  logic              w_we;
  logic              w_re;
  logic [31:0]       w_arr_rdata;

  assign w_req     = bus.mem_read | bus.mem_write;
  assign w_in_idle = (r_state == ST_IDLE);

  // With zero wait states the commit happens on the accepting edge itself,
  // before the captured registers hold the request, so the live bus is used
  // while in IDLE. A simultaneous read+write is a write only.
  assign w_op_wr    = w_in_idle ? bus.mem_write                    : r_is_wr;
  assign w_op_rd    = w_in_idle ? (bus.mem_read & ~bus.mem_write)  : r_is_rd;
  assign w_op_addr  = w_in_idle ? bus.addr                         : r_addr;
  assign w_op_wdata = w_in_idle ? bus.wdata                        : r_wdata;

  assign w_enter_done = (w_in_idle && w_req && ZERO_WAIT) ||
                        ((r_state == ST_WAIT) && (r_cnt == '0));

`ifdef MEM_RESPONDER_BUSERR_EN
  assign w_err = (w_op_addr[1:0] != 2'b00) ||
                 ((w_op_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
`else
  logic w_unused_addr;
  assign w_err         = 1'b0;
  assign w_unused_addr = ^{w_op_addr[31:DEPTH_LOG2+2], w_op_addr[1:0]};
`endif

  assign w_we = w_enter_done & w_op_wr & ~w_err;
  assign w_re = w_enter_done & w_op_rd & ~w_err;

  mem_responder_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_WORD  (INIT_WORD)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_idx   (w_op_addr[DEPTH_LOG2+1:2]),
    .i_wdata (w_op_wdata),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
      r_is_rd <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          if (w_req) begin
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_is_wr <= bus.mem_write;
            r_is_rd <= bus.mem_read & ~bus.mem_write;
            if (ZERO_WAIT) begin
              r_state <= ST_DONE;
              r_ready <= 1'b1;
              r_err   <= w_err;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_DONE;
            r_ready <= 1'b1;
            r_err   <= w_err;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_err   <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_RESPONDER_BUSERR_EN
  // Remembers whether the last completed read faulted, so ERR_WORD is held
  // on rdata exactly as long as a good read's data would be.
  logic r_rd_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_err <= 1'b0;
    end else if (w_enter_done && w_op_rd) begin
      r_rd_err <= w_err;
    end
  end

  assign bus.rdata = r_rd_err ? ERR_WORD : w_arr_rdata;
`else
  assign bus.rdata = w_arr_rdata;
`endif

  assign bus.ready = r_ready;
  assign bus.err   = r_err;
  // Strobes are masked while reset is held.
  assign bus.busy  = rst & (~w_in_idle | w_req);

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Directed bench for mem_responder. Three instances (WAIT_CYCLES 0, 1, 3)
// share one set of request inputs; "sel" picks which instance's outputs a
// transaction is judged on. Expected values are hand-derived constants.
module tb_mem_responder;

  localparam int W0 = 0;
  localparam int W1 = 1;
  localparam int W3 = 3;
  localparam logic [31:0] INIT0 = 32'hCAFE_0001;
  localparam logic [31:0] INIT1 = 32'h0000_0000;
  localparam logic [31:0] INIT3 = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        t_rd;
  logic        t_wr;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  int          sel;

  int n_checks;
  int n_errors;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();
  mem_responder_if bus3 ();

  assign bus0.mem_read = t_rd;  assign bus0.mem_write = t_wr;
  assign bus0.addr     = t_addr; assign bus0.wdata    = t_wdata;
  assign bus1.mem_read = t_rd;  assign bus1.mem_write = t_wr;
  assign bus1.addr     = t_addr; assign bus1.wdata    = t_wdata;
  assign bus3.mem_read = t_rd;  assign bus3.mem_write = t_wr;
  assign bus3.addr     = t_addr; assign bus3.wdata    = t_wdata;

  mem_responder #(.DEPTH_LOG2(4),  .WAIT_CYCLES(W0), .INIT_WORD(INIT0))
    u_w0 (.clk(clk), .rst(rst), .bus(bus0));
  mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(W1), .INIT_WORD(INIT1))
    u_w1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_responder #(.DEPTH_LOG2(4),  .WAIT_CYCLES(W3), .INIT_WORD(INIT3))
    u_w3 (.clk(clk), .rst(rst), .bus(bus3));

  logic        o_rdy;
  logic        o_busy;
  logic        o_err;
  logic [31:0] o_rdata;

  always_comb begin
    o_rdy   = bus1.ready;
    o_busy  = bus1.busy;
    o_err   = bus1.err;
    o_rdata = bus1.rdata;
    if (sel == 0) begin
      o_rdy = bus0.ready; o_busy = bus0.busy; o_err = bus0.err; o_rdata = bus0.rdata;
    end else if (sel == 3) begin
      o_rdy = bus3.ready; o_busy = bus3.busy; o_err = bus3.err; o_rdata = bus3.rdata;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int exp_lat(input int s);
    if (s == 0) return W0 + 1;
    if (s == 1) return W1 + 1;
    return W3 + 1;
  endfunction

  // Waits (bounded) until every instance has dropped busy.
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((bus0.busy || bus1.busy || bus3.busy) && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk_eq({tag, "_idle"}, 32'(n < 12), 32'd1);
  endtask

  // One request on the shared bus, judged on instance s. Latency counts the
  // cycle beginning at the accepting edge as cycle 1.
  task automatic do_access(input int s, input logic wr, input logic rd,
                           input logic [31:0] a, input logic [31:0] wd,
                           input string tag,
                           output logic [31:0] rdo, output logic erro);
    int lat;
    sel = s;
    @(negedge clk);
    t_wr = wr; t_rd = rd; t_addr = a; t_wdata = wd;
    #1;
    chk_eq({tag, "_busy_req"}, 32'(o_busy), 32'd1);
    @(posedge clk);
    #1;
    t_wr = 1'b0; t_rd = 1'b0;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (o_rdy) begin
        lat = n;
        break;
      end
      chk_eq({tag, "_busy_wait"}, 32'(o_busy), 32'd1);
    end
    chk_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat(s)));
    rdo  = o_rdata;
    erro = o_err;
    @(negedge clk);
    chk_eq({tag, "_rdy_1cyc"}, 32'(o_rdy), 32'd0);
    wait_idle(tag);
  endtask

  logic [31:0] rv;
  logic        ev;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    sel = 1;
    rst = 1'b0; t_rd = 1'b1; t_wr = 1'b0; t_addr = '0; t_wdata = '0;

    // Reset state, with a strobe held to show busy is masked
    repeat (3) @(negedge clk);
    chk_eq("rst_busy",  32'(bus1.busy),  32'd0);
    chk_eq("rst_ready", 32'(bus1.ready), 32'd0);
    chk_eq("rst_err",   32'(bus1.err),   32'd0);
    chk_eq("rst_rdata", bus1.rdata,      32'd0);
    chk_eq("rst_rdata0", bus0.rdata,     32'd0);
    t_rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back reads of 0x0 with strobe held, zero wait states
    sel = 0;
    t_rd = 1'b1; t_addr = 32'h0;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_eq($sformatf("b2b_rdy%0d", i), 32'(o_rdy), 32'((i % 2) == 0));
      chk_eq($sformatf("b2b_busy%0d", i), 32'(o_busy), 32'd1);
      chk_eq($sformatf("b2b_rdata%0d", i), o_rdata, INIT0);
    end
    t_rd = 1'b0;
    wait_idle("b2b");

    // Write then read 0x10, one wait state
    do_access(1, 1'b1, 1'b0, 32'h10, 32'h1234_5678, "wr10", rv, ev);
    chk_eq("wr10_rdata", rv, 32'd0);
    chk_eq("wr10_err", 32'(ev), 32'd0);
    do_access(1, 1'b0, 1'b1, 32'h10, 32'h0, "rd10", rv, ev);
    chk_eq("rd10_rdata", rv, 32'h1234_5678);
    chk_eq("rd10_err", 32'(ev), 32'd0);

    // Three wait states (strobe dropped after accept) and zero wait states
    do_access(3, 1'b0, 1'b1, 32'h10, 32'h0, "rd10_w3", rv, ev);
    chk_eq("rd10_w3_rdata", rv, 32'h1234_5678);
    do_access(0, 1'b0, 1'b1, 32'h10, 32'h0, "rd10_w0", rv, ev);
    chk_eq("rd10_w0_rdata", rv, 32'h1234_5678);

    // Simultaneous read+write is a write only
    do_access(1, 1'b1, 1'b1, 32'h8, 32'hA5A5_A5A5, "rw8", rv, ev);
    chk_eq("rw8_rdata_held", rv, 32'h1234_5678);
    do_access(1, 1'b0, 1'b1, 32'h8, 32'h0, "rd8", rv, ev);
    chk_eq("rd8_rdata", rv, 32'hA5A5_A5A5);

    // Reset during the wait state of a write to 0x20
    sel = 1;
    @(negedge clk);
    t_wr = 1'b1; t_addr = 32'h20; t_wdata = 32'h7777_7777;
    @(posedge clk);
    #1;
    t_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_eq("abort_ready", 32'(o_rdy), 32'd0);
    chk_eq("abort_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ev = ev | o_rdy;
    end
    chk_eq("abort_no_ready", 32'(ev), 32'd0);
    chk_eq("abort_rdata", o_rdata, 32'd0);
    do_access(1, 1'b0, 1'b1, 32'h20, 32'h0, "rd20", rv, ev);
    chk_eq("rd20_rdata", rv, INIT1);
    do_access(0, 1'b0, 1'b1, 32'h20, 32'h0, "rd20_w0", rv, ev);
    chk_eq("rd20_w0_rdata", rv, INIT0);
    do_access(1, 1'b0, 1'b1, 32'h10, 32'h0, "rd10_post", rv, ev);
    chk_eq("rd10_post_rdata", rv, INIT1);

    // Misaligned / out-of-range addresses
    do_access(1, 1'b1, 1'b0, 32'h0, 32'h0BAD_F00D, "wr0", rv, ev);
    chk_eq("wr0_err", 32'(ev), 32'd0);
    do_access(1, 1'b0, 1'b1, 32'h1002, 32'h0, "rd1002", rv, ev);
`ifdef MEM_RESPONDER_BUSERR_EN
    chk_eq("rd1002_rdata", rv, 32'hDEAD_BEEF);
    chk_eq("rd1002_err", 32'(ev), 32'd1);
`else
    chk_eq("rd1002_rdata", rv, 32'h0BAD_F00D);
    chk_eq("rd1002_err", 32'(ev), 32'd0);
`endif
    do_access(1, 1'b1, 1'b0, 32'h1004, 32'hFFFF_0000, "wr1004", rv, ev);
`ifdef MEM_RESPONDER_BUSERR_EN
    chk_eq("wr1004_err", 32'(ev), 32'd1);
`else
    chk_eq("wr1004_err", 32'(ev), 32'd0);
`endif
    do_access(1, 1'b0, 1'b1, 32'h4, 32'h0, "rd4", rv, ev);
    chk_eq("rd4_err", 32'(ev), 32'd0);
`ifdef MEM_RESPONDER_BUSERR_EN
    chk_eq("rd4_rdata", rv, INIT1);
`else
    chk_eq("rd4_rdata", rv, 32'hFFFF_0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
